// File: rtl/rom_loader.sv
// rom_loader: writes a length-prefixed host byte stream into the cpu ROM from ROM_ADDR and releases cpu reset.
// Latency: each accepted payload byte appears on the ROM write port one cycle later; done/cpu_reset follow one cycle after the last write.
// Backpressure: in_ready is registered, high only while loading (LEN/DATA/CRC); optional trailer check under `ROM_LOADER_CRC_EN`.
module rom_loader #(
  parameter int          ROM_ADDR = 4,
  parameter int          ADDR_W   = 16,
  parameter int unsigned ROM_SIZE = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              done,
  output logic [1:0]        error
);

  // Largest payload that fits between ROM_ADDR and the top of the ROM.
  localparam logic [31:0] MAX_LEN = 32'(ROM_SIZE - ROM_ADDR);

`ifdef ROM_LOADER_CRC_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CRC, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;
`endif

  state_t      state_q, state_n;
  logic [1:0]  byte_cnt;
  logic [31:0] len_q;
  logic [31:0] idx_q;
  logic [31:0] len_full;
  logic        beat;

  logic              in_ready_d, mem_we_d, done_d, cpu_reset_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_data_d;
  logic [1:0]        error_d;

`ifdef ROM_LOADER_CRC_EN
  logic [7:0] crc_q;

  // CRC-8, poly 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign beat     = in_valid && in_ready;
  // Length as it will be once the current (4th) header byte is merged in.
  assign len_full = {in_data, len_q[23:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LEN;
    else       state_q <= state_n;
  end

  // Next-state logic: header, payload, optional trailer, then terminal RUN/ERR.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_LEN: begin
        if (beat && byte_cnt == 2'd3) begin
          if (len_full > MAX_LEN) begin
            state_n = S_ERR;
          end else if (len_full == 32'd0) begin
`ifdef ROM_LOADER_CRC_EN
            state_n = S_CRC;
`else
            state_n = S_RUN;
`endif
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (beat && idx_q == len_q - 32'd1) begin
`ifdef ROM_LOADER_CRC_EN
          state_n = S_CRC;
`else
          state_n = S_RUN;
`endif
        end
      end
`ifdef ROM_LOADER_CRC_EN
      S_CRC: begin
        if (beat) state_n = (in_data == crc_q) ? S_RUN : S_ERR;
      end
`endif
      S_RUN:   state_n = S_RUN;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_LEN;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    in_ready_d  = (state_n == S_LEN) || (state_n == S_DATA)
`ifdef ROM_LOADER_CRC_EN
                  || (state_n == S_CRC)
`endif
                  ;
    mem_we_d    = beat && (state_q == S_DATA);
    mem_addr_d  = mem_addr;
    mem_data_d  = mem_data;
    if (mem_we_d) begin
      mem_addr_d = ADDR_W'(32'(ROM_ADDR) + idx_q);
      mem_data_d = in_data;
    end
    // done trails the state by one edge so it lands one cycle after the last write.
    done_d      = (state_q == S_RUN);
    cpu_reset_d = !done_d;
    error_d     = error;
    if (state_q == S_LEN && state_n == S_ERR) error_d = 2'd1;
`ifdef ROM_LOADER_CRC_EN
    if (state_q == S_CRC && state_n == S_ERR) error_d = 2'd2;
`endif
  end

  // Header/payload bookkeeping: length assembly, write index and running CRC.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      len_q    <= 32'd0;
      idx_q    <= 32'd0;
`ifdef ROM_LOADER_CRC_EN
      crc_q    <= 8'd0;
`endif
    end else if (beat) begin
      if (state_q == S_LEN) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          len_q <= len_full;
          idx_q <= 32'd0;
`ifdef ROM_LOADER_CRC_EN
          crc_q <= 8'd0;
`endif
        end else begin
          len_q[{byte_cnt, 3'b000} +: 8] <= in_data;
        end
      end else if (state_q == S_DATA) begin
        idx_q <= idx_q + 32'd1;
`ifdef ROM_LOADER_CRC_EN
        crc_q <= crc8_step(crc_q, in_data);
`endif
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= 8'd0;
      done      <= 1'b0;
      error     <= 2'd0;
      cpu_reset <= 1'b1;
    end else begin
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_data  <= mem_data_d;
      done      <= done_d;
      error     <= error_d;
      cpu_reset <= cpu_reset_d;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: per-cycle vector table for the basic image plus scoreboarded sequences
// for gaps, zero length, overflow, length boundary, mid-load reset and (with ROM_LOADER_CRC_EN) trailer checks.
module tb_rom_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_reset;
  logic        done;
  logic [1:0]  error;

  rom_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  int cyc = 0;
  int last_we_cyc = -100;
  int done_lag = -1;
  bit sb_en = 1'b0;
  bit halt_watch = 1'b0;
  int halt_viol = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write the DUT issues must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (mem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_data), 32'(e.data));
        end
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_lag = cyc - last_we_cyc;
    done_prev = done;
    if (halt_watch && cpu_reset !== 1'b1) halt_viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout actual=%0b required=1", in_ready);
    end else begin
      in_data = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_header(input int n, input int gap);
    logic [31:0] l;
    l = 32'(n);
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], gap);
  endtask

  function automatic logic [7:0] crc8(input byte_q_t p);
    logic [7:0] c;
    c = 8'h00;
    foreach (p[i]) begin
      c = c ^ p[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic send_image(input byte_q_t p, input int gap);
    wr_t e;
    send_header(p.size(), gap);
    foreach (p[i]) begin
      e.addr = 16'(4 + i);
      e.data = p[i];
      exp_q.push_back(e);
      send_byte(p[i], gap);
    end
`ifdef ROM_LOADER_CRC_EN
    send_byte(crc8(p), gap);
`endif
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while (done !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [15:0] a;
    logic [7:0]  md;
    logic        rdy;
    logic        dn;
    logic        cr;
  } vec_t;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img;
    byte_q_t crc_img;
    vec_t tv[11];
    wr_t e;
    img = '{8'h20, 8'h00, 8'h41, 8'h01};

    // Reset state.
    do_reset(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);

`ifndef ROM_LOADER_CRC_EN
    // Basic image, cycle by cycle: 04 00 00 00 20 00 41 01, then a byte that must be refused.
    tv[0]  = '{1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 8'h04, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 8'h00, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 8'h20, 1'b1, 16'h4, 8'h20, 1'b1, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 8'h00, 1'b1, 16'h5, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 8'h41, 1'b1, 16'h6, 8'h41, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 8'h01, 1'b1, 16'h7, 8'h01, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b1, 8'hFF, 1'b0, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      in_valid = tv[i].v;
      in_data  = tv[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(tv[i].we));
      if (tv[i].we) begin
        check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(tv[i].a));
        check($sformatf("vec%0d_data", i), 32'(mem_data), 32'(tv[i].md));
      end
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tv[i].rdy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(tv[i].dn));
      check($sformatf("vec%0d_cpu_reset", i), 32'(cpu_reset), 32'(tv[i].cr));
      check($sformatf("vec%0d_error", i), 32'(error), 32'd0);
    end
    in_valid = 1'b0;
    #1;
`endif

    // Same image with a one-cycle gap after every beat.
    do_reset(2);
    sb_en = 1'b1;
    send_image(img, 1);
    wait_done("gap");
    check("gap_done_lag", 32'(done_lag), 32'd1);
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length image: no writes, done two edges after the 4th header beat.
    do_reset(2);
    send_header(0, 0);
`ifdef ROM_LOADER_CRC_EN
    send_byte(8'h00, 0);
`endif
    check("len0_done_early", 32'(done), 32'd0);
    tick();
    check("len0_done", 32'(done), 32'd1);
    check("len0_cpu_reset", 32'(cpu_reset), 32'd0);
    check("len0_in_ready", 32'(in_ready), 32'd0);

    // Length one past the usable payload: error 1 and nothing accepted or written.
    do_reset(2);
    send_header(65533, 0);
    tick();
    tick();
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    check("ovf_error_held", 32'(error), 32'd1);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Exactly the usable payload length is accepted.
    do_reset(2);
    send_header(65532, 0);
    tick();
    check("max_len_error", 32'(error), 32'd0);
    check("max_len_in_ready", 32'(in_ready), 32'd1);

    // Reset after two payload bytes, then a full reload restarting at address 4.
    do_reset(2);
    halt_viol = 0;
    halt_watch = 1'b1;
    send_header(4, 0);
    for (int i = 0; i < 2; i++) begin
      e.addr = 16'(4 + i);
      e.data = img[i];
      exp_q.push_back(e);
      send_byte(img[i], 0);
    end
    tick();
    tick();
    check("mid_partial_written", 32'(exp_q.size()), 32'd0);
    do_reset(2);
    send_image(img, 0);
    halt_watch = 1'b0;
    check("mid_cpu_reset_held", 32'(halt_viol), 32'd0);
    wait_done("mid");
    check("mid_done_lag", 32'(done_lag), 32'd1);
    check("mid_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef ROM_LOADER_CRC_EN
    // "123456789" with its CRC-8 trailer F4 loads; F5 is rejected.
    crc_img = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    do_reset(2);
    send_header(9, 0);
    foreach (crc_img[i]) begin
      e.addr = 16'(4 + i);
      e.data = crc_img[i];
      exp_q.push_back(e);
      send_byte(crc_img[i], 0);
    end
    send_byte(8'hF4, 0);
    wait_done("crc_good");
    check("crc_good_error", 32'(error), 32'd0);
    do_reset(2);
    send_header(9, 0);
    foreach (crc_img[i]) begin
      e.addr = 16'(4 + i);
      e.data = crc_img[i];
      exp_q.push_back(e);
      send_byte(crc_img[i], 0);
    end
    send_byte(8'hF5, 0);
    tick();
    tick();
    check("crc_bad_error", 32'(error), 32'd2);
    check("crc_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("crc_bad_done", 32'(done), 32'd0);
`else
    crc_img = '{};
    check("no_crc_trailer_len", 32'(crc_img.size()), 32'(crc8(crc_img) == 8'h00 ? 0 : 1));
`endif

    tick();
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
